// File: rtl/motor_cmd_pkg.sv
// Shared types and constants for the motor-command arbiter: command payload,
// requester source encoding and arbiter FSM states.
package motor_cmd_pkg;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_AUTO  = 2'd1,
    SRC_MAN   = 2'd2,
    SRC_ESTOP = 2'd3
  } src_t;

  typedef struct packed {
    logic [2:0] code;
    logic       neg_l;
    logic       neg_r;
  } motor_cmd_t;

  typedef struct packed {
    motor_cmd_t cmd;
    src_t       src;
  } arb_req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_t;

  localparam logic [2:0] CODE_STOP = 3'b000;

  localparam arb_req_t REQ_STOP_NONE = '{
    cmd: '{code: CODE_STOP, neg_l: 1'b0, neg_r: 1'b0},
    src: SRC_NONE
  };

  // A stop never carries reverse flags, whatever the requester asked for.
  function automatic motor_cmd_t force_fwd(input logic [2:0] code,
                                           input logic       neg_l,
                                           input logic       neg_r);
    motor_cmd_t c;
    c.code  = code;
    c.neg_l = (code == CODE_STOP) ? 1'b0 : neg_l;
    c.neg_r = (code == CODE_STOP) ? 1'b0 : neg_r;
    return c;
  endfunction

endpackage

// File: rtl/motor_cmd_arbiter_if.sv
// Valid/ready command channel between the arbiter and the uart_comm transmitter.
interface motor_cmd_if;

  logic [2:0] cmd_code;
  logic       cmd_neg_l;
  logic       cmd_neg_r;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (
    output cmd_code, cmd_neg_l, cmd_neg_r, cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_code, cmd_neg_l, cmd_neg_r, cmd_valid,
    output cmd_ready
  );

endinterface

// File: rtl/motor_cmd_arbiter_cmd_timer.sv
// Saturating up-counter with synchronous clear; expire_o is high while the
// count sits at LIMIT-1.
module cmd_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/motor_cmd_arbiter.sv
// Shares the uart_comm motor-command transmitter between estop, manual and
// autonomous requesters; sends on change and refreshes periodically.
module motor_cmd_arbiter
  import motor_cmd_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 25_000_000,
  parameter int unsigned AUTO_TIMEOUT   = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             estop,
  input  logic             man_en,
  input  logic [2:0]       man_code,
  input  logic             man_neg_l,
  input  logic             man_neg_r,
  input  logic             auto_valid,
  input  logic [2:0]       auto_code,
  input  logic             auto_neg_l,
  input  logic             auto_neg_r,
  motor_cmd_if.master      cmd,
  output logic [1:0]       active_src,
  output logic             auto_stale
);

  arb_state_t state_q, state_d;
  arb_req_t   want_q, want_d;
  arb_req_t   sent_q, sent_d;
  arb_req_t   pay_q, pay_d;
  motor_cmd_t auto_q, auto_d;
  src_t       active_src_q, active_src_d;
  logic       valid_q, valid_d;
  logic       auto_stale_q, auto_stale_d;
  logic       accept, refresh_due, fresh_expire;

  assign accept = valid_q && cmd.cmd_ready;

  cmd_timer #(.LIMIT(REFRESH_CYCLES)) u_refresh (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept),
    .en_i     (state_q != ST_ISSUE),
    .expire_o (refresh_due)
  );

  cmd_timer #(.LIMIT(AUTO_TIMEOUT)) u_fresh (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (auto_valid),
    .en_i     (1'b1),
    .expire_o (fresh_expire)
  );

  always_comb begin
    auto_d       = auto_q;
    auto_stale_d = auto_stale_q;
    if (auto_valid) begin
      auto_d.code  = auto_code;
      auto_d.neg_l = auto_neg_l;
      auto_d.neg_r = auto_neg_r;
      auto_stale_d = 1'b0;
    end else if (fresh_expire) begin
      auto_stale_d = 1'b1;
    end else begin
      auto_stale_d = auto_stale_q;
    end
  end

  always_comb begin
    want_d = REQ_STOP_NONE;
    if (estop) begin
      want_d.src = SRC_ESTOP;
    end else if (man_en) begin
      want_d.cmd = force_fwd(man_code, man_neg_l, man_neg_r);
      want_d.src = SRC_MAN;
    end else if (!auto_stale_q) begin
      want_d.cmd = force_fwd(auto_q.code, auto_q.neg_l, auto_q.neg_r);
      want_d.src = SRC_AUTO;
    end else begin
      want_d = REQ_STOP_NONE;
    end
  end

  // Payload is frozen from IDLE exit until accept; later requests wait for IDLE.
  always_comb begin
    state_d      = state_q;
    pay_d        = pay_q;
    valid_d      = valid_q;
    sent_d       = sent_q;
    active_src_d = active_src_q;
    case (state_q)
      ST_IDLE: begin
        if ((want_q != sent_q) || refresh_due) begin
          state_d = ST_ISSUE;
          pay_d   = want_q;
          valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          sent_d       = pay_q;
          active_src_d = pay_q.src;
          valid_d      = 1'b0;
          state_d      = ST_BUSY;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_BUSY: begin
        if (cmd.cmd_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      want_q       <= REQ_STOP_NONE;
      sent_q       <= REQ_STOP_NONE;
      pay_q        <= REQ_STOP_NONE;
      valid_q      <= 1'b0;
      active_src_q <= SRC_NONE;
      auto_q       <= '0;
      auto_stale_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      want_q       <= want_d;
      sent_q       <= sent_d;
      pay_q        <= pay_d;
      valid_q      <= valid_d;
      active_src_q <= active_src_d;
      auto_q       <= auto_d;
      auto_stale_q <= auto_stale_d;
    end
  end

  assign cmd.cmd_code  = pay_q.cmd.code;
  assign cmd.cmd_neg_l = pay_q.cmd.neg_l;
  assign cmd.cmd_neg_r = pay_q.cmd.neg_r;
  assign cmd.cmd_valid = valid_q;
  assign active_src    = active_src_q;
  assign auto_stale    = auto_stale_q;

endmodule
